imm_encoder: RTL

- Inverse of the operand-2 generator: takes a 32-bit constant and produces the 12-bit shift_operand encoding that regenerates it, or flags it as not encodable.
- Data-processing immediates use the rotate form: value = imm8 rotated right by 2*rot.
- Memory offsets use the plain 12-bit form: value = {20'b0, offset12}.
- Sits beside the instruction path for the loader and self-check logic. Start/done handshake; iterative rotation search.

---
 rtl/imm_encoder_pkg.sv | 22 ++
 rtl/imm_rot_check.sv | 18 +
 rtl/imm_encoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared constants, FSM state encoding and rotate helper for the immediate encoder.
// The IMM_ENCODER_FAST_EN build option (parallel rotation search) is selected in imm_encoder.sv.
package imm_encoder_pkg;

    localparam int REGISTER_LEN = 32;
    localparam int ROT_STEPS    = 16;

    typedef enum logic [1:0] {
        IMM_ENC_IDLE   = 2'd0,
        IMM_ENC_SEARCH = 2'd1,
        IMM_ENC_DONE   = 2'd2
    } imm_enc_state_t;

    // Rotate left by 2*r; the doubled word makes the wrap-around fall out of a plain shift.
    function automatic logic [REGISTER_LEN-1:0] rotl2(input logic [REGISTER_LEN-1:0] v,
                                                      input logic [3:0]              r);
        logic [2*REGISTER_LEN-1:0] t;
        t = {v, v} << {r, 1'b0};
        return t[2*REGISTER_LEN-1:REGISTER_LEN];
    endfunction

endpackage

// File: rtl/imm_rot_check.sv
// Combinational check of one rotation: does value rotated left by 2*r fit in 8 bits?
// imm8 is the low byte of that rotated candidate.
module imm_rot_check
    import imm_encoder_pkg::*;
(
    input  logic [REGISTER_LEN-1:0] value,
    input  logic [3:0]              r,
    output logic                    match,
    output logic [7:0]              imm8
);

    logic [REGISTER_LEN-1:0] cand;

    assign cand  = rotl2(value, r);
    assign match = (cand[REGISTER_LEN-1:8] == '0);
    assign imm8  = cand[7:0];

endmodule

// File: rtl/imm_encoder.sv
// Encodes a 32-bit constant as a 12-bit rotate-immediate or memory offset, one rotation per cycle.
// IMM_ENCODER_FAST_EN: all 16 rotations checked in parallel, result one edge after start.
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [REGISTER_LEN-1:0] value,
    input  logic                    is_mem_command,
    output logic                    busy,
    output logic                    done,
    output logic                    encodable,
    output logic [11:0]             shift_operand,
    output logic                    immediate
);

    imm_enc_state_t state, state_nxt;
    logic           enc_nxt;
    logic [11:0]    so_nxt;
    logic           imm_nxt;

`ifdef IMM_ENCODER_FAST_EN
    logic [ROT_STEPS-1:0] hit;
    logic [7:0]           imm_arr [ROT_STEPS];
    logic                 fast_hit;
    logic [3:0]           fast_rot;
    logic [7:0]           fast_imm;

    for (genvar g = 0; g < ROT_STEPS; g++) begin : g_chk
        imm_rot_check u_chk (
            .value (value),
            .r     (4'(g)),
            .match (hit[g]),
            .imm8  (imm_arr[g])
        );
    end

    // Walk downward so the lowest matching rotation is the one left standing.
    always_comb begin
        fast_hit = 1'b0;
        fast_rot = 4'd0;
        fast_imm = 8'd0;
        for (int i = ROT_STEPS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                fast_hit = 1'b1;
                fast_rot = 4'(i);
                fast_imm = imm_arr[i];
            end
        end
    end
`else
    logic [REGISTER_LEN-1:0] val_q, val_nxt;
    logic [3:0]              rot, rot_nxt;
    logic                    chk_match;
    logic [7:0]              chk_imm8;

    imm_rot_check u_chk (
        .value (val_q),
        .r     (rot),
        .match (chk_match),
        .imm8  (chk_imm8)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
            rot   <= 4'd0;
        end else begin
            val_q <= val_nxt;
            rot   <= rot_nxt;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IMM_ENC_IDLE;
            encodable     <= 1'b0;
            shift_operand <= 12'd0;
            immediate     <= 1'b0;
        end else begin
            state         <= state_nxt;
            encodable     <= enc_nxt;
            shift_operand <= so_nxt;
            immediate     <= imm_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        enc_nxt   = encodable;
        so_nxt    = shift_operand;
        imm_nxt   = immediate;
`ifndef IMM_ENCODER_FAST_EN
        val_nxt   = val_q;
        rot_nxt   = rot;
`endif
        case (state)
            IMM_ENC_IDLE: begin
                if (start) begin
                    imm_nxt = !is_mem_command;
                    if (is_mem_command) begin
                        enc_nxt   = (value[REGISTER_LEN-1:12] == '0);
                        so_nxt    = enc_nxt ? value[11:0] : 12'd0;
                        state_nxt = IMM_ENC_DONE;
                    end else begin
`ifdef IMM_ENCODER_FAST_EN
                        enc_nxt   = fast_hit;
                        so_nxt    = fast_hit ? {fast_rot, fast_imm} : 12'd0;
                        state_nxt = IMM_ENC_DONE;
`else
                        val_nxt   = value;
                        rot_nxt   = 4'd0;
                        enc_nxt   = 1'b0;
                        so_nxt    = 12'd0;
                        state_nxt = IMM_ENC_SEARCH;
`endif
                    end
                end
            end
            IMM_ENC_SEARCH: begin
`ifdef IMM_ENCODER_FAST_EN
                state_nxt = IMM_ENC_IDLE;
`else
                if (chk_match) begin
                    enc_nxt   = 1'b1;
                    so_nxt    = {rot, chk_imm8};
                    state_nxt = IMM_ENC_DONE;
                end else if (rot == 4'd15) begin
                    enc_nxt   = 1'b0;
                    so_nxt    = 12'd0;
                    state_nxt = IMM_ENC_DONE;
                end else begin
                    rot_nxt = rot + 4'd1;
                end
`endif
            end
            IMM_ENC_DONE: state_nxt = IMM_ENC_IDLE;
            default:      state_nxt = IMM_ENC_IDLE;
        endcase
    end

    assign done = (state == IMM_ENC_DONE);
    assign busy = (state != IMM_ENC_IDLE);

endmodule
